// File: rtl/fifo_pong_merge.sv
// Two-lane merge: per-lane DEPTH-entry buffers drained strictly alternating lane 0, lane 1.
// Optional FIFO_PONG_MERGE_PIPE_EN lets a full lane accept in the same cycle its head is dequeued.
module fifo_pong_merge #(
    parameter int unsigned WIDTH = 704,
    parameter int unsigned DEPTH = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in0_enq__ENA,
    input  logic [WIDTH-1:0] in0_enq_v,
    output logic             in0_enq__RDY,
    input  logic             in1_enq__ENA,
    input  logic [WIDTH-1:0] in1_enq_v,
    output logic             in1_enq__RDY,
    input  logic             out_deq__ENA,
    output logic             out_deq__RDY,
    output logic [WIDTH-1:0] out_first,
    output logic             out_first__RDY,
    output logic             out_lane
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} lane_e;

    lane_e            turn_q, turn_d;
    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [AW-1:0]    rd_q  [2];
    logic [AW-1:0]    rd_d  [2];
    logic [AW-1:0]    wr_q  [2];
    logic [AW-1:0]    wr_d  [2];
    logic [CW-1:0]    cnt_q [2];
    logic [CW-1:0]    cnt_d [2];
    logic [WIDTH-1:0] data  [2];
    logic [1:0]       ena;
    logic [1:0]       rdy;
    logic [1:0]       enq_fire;
    logic [1:0]       deq_lane;
    logic             cur;
    logic             head_vld;
    logic             deq_fire;

    assign ena      = {in1_enq__ENA, in0_enq__ENA};
    assign data[0]  = in0_enq_v;
    assign data[1]  = in1_enq_v;
    assign cur      = turn_q;
    assign head_vld = (cnt_q[cur] != '0);
    assign deq_fire = out_deq__ENA & head_vld;

    always_comb begin
        rdy      = '0;
        enq_fire = '0;
        deq_lane = '0;
        for (int unsigned n = 0; n < 2; n++) begin
            deq_lane[n] = deq_fire & (int'(cur) == int'(n));
`ifdef FIFO_PONG_MERGE_PIPE_EN
            // A dequeue from this lane frees a slot in time for a same-edge write.
            rdy[n] = (cnt_q[n] != FULL) | deq_lane[n];
`else
            rdy[n] = (cnt_q[n] != FULL);
`endif
            enq_fire[n] = ena[n] & rdy[n];
        end
    end

    always_comb begin
        turn_d = turn_q;
        for (int unsigned n = 0; n < 2; n++) begin
            rd_d[n]  = rd_q[n];
            wr_d[n]  = wr_q[n];
            cnt_d[n] = cnt_q[n] + CW'(enq_fire[n]) - CW'(deq_lane[n]);
            if (enq_fire[n]) wr_d[n] = wr_q[n] + 1'b1;
            if (deq_lane[n]) rd_d[n] = rd_q[n] + 1'b1;
        end
        if (deq_fire) turn_d = (turn_q == LANE0) ? LANE1 : LANE0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            turn_q <= LANE0;
            for (int unsigned n = 0; n < 2; n++) begin
                rd_q[n]  <= '0;
                wr_q[n]  <= '0;
                cnt_q[n] <= '0;
            end
        end else begin
            turn_q <= turn_d;
            for (int unsigned n = 0; n < 2; n++) begin
                rd_q[n]  <= rd_d[n];
                wr_q[n]  <= wr_d[n];
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Storage is never cleared; reset only gates writes so reset-cycle ENA is dropped.
    always_ff @(posedge CLK) begin
        for (int unsigned n = 0; n < 2; n++) begin
            if (nRST && enq_fire[n]) mem_q[n][wr_q[n]] <= data[n];
        end
    end

    assign in0_enq__RDY   = rdy[0];
    assign in1_enq__RDY   = rdy[1];
    assign out_deq__RDY   = head_vld;
    assign out_first__RDY = head_vld;
    assign out_first      = head_vld ? mem_q[cur][rd_q[cur]] : '0;
    assign out_lane       = cur;

endmodule

// File: doc/fifo_pong_merge.md
Name: fifo_pong_merge

Overview:
- Reassembles one in-order stream from two alternating lanes, such as the split halves of a ping-pong FIFO pair or two parallel workers fed round-robin.
- Each lane has its own DEPTH-entry buffer; the output strictly alternates lane 0, lane 1, lane 0, and so on.
- Uses the codebase ENA/RDY method-style handshake on every port.

Parameters:
- WIDTH, 704, payload width in bits.
- DEPTH, 2, entries per lane buffer; power of two, minimum 2.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- nRST  input  1  reset, synchronous, active-low.
- in0_enq__ENA  input  1  enqueue request, lane 0.
- in0_enq_v  input  WIDTH  lane 0 payload.
- in0_enq__RDY  output  1  lane 0 can accept.
- in1_enq__ENA  input  1  enqueue request, lane 1.
- in1_enq_v  input  WIDTH  lane 1 payload.
- in1_enq__RDY  output  1  lane 1 can accept.
- out_deq__ENA  input  1  dequeue request.
- out_deq__RDY  output  1  head of current lane valid.
- out_first  output  WIDTH  head payload of current lane.
- out_first__RDY  output  1  same as out_deq__RDY.
- out_lane  output  1  lane currently selected (the turn bit).

Behaviour:
- State:
  - turn bit.
  - Per lane: DEPTH x WIDTH storage, rd_ptr and wr_ptr of log2(DEPTH) bits, count of log2(DEPTH)+1 bits.
- Reset (nRST low at a clock edge):
  - turn=0; all pointers and counts 0; storage contents are not cleared.
  - Resulting outputs: in0_enq__RDY=1, in1_enq__RDY=1, out_deq__RDY=0, out_first__RDY=0, out_first=0, out_lane=0.
  - Reset mid-operation discards all buffered data. Any ENA sampled in the reset cycle is ignored.
- Internal enables: each internal enable = ENA & RDY. An ENA presented while RDY=0 has no effect and is not remembered.
- inN_enq__RDY = (countN != DEPTH).
- Enqueue on lane N:
  - storageN[wr_ptrN] <= inN_enq_v; wr_ptrN increments, wrapping DEPTH-1 to 0; countN+1.
- out_deq__RDY = out_first__RDY = (count[turn] != 0).
- out_first:
  - storage[turn][rd_ptr[turn]] when ready; all-zero when not ready.
  - Combinational; available in the same cycle as the data becomes visible (see latency).
- Dequeue:
  - rd_ptr[turn] increments with wrap; count[turn]-1; turn <= ~turn.
- Turn rules:
  - turn never advances except on a dequeue.
  - A non-empty lane that is not the current turn stays invisible. Lane 1 data never bypasses a missing lane 0 item.
- Simultaneous events:
  - Enqueue and dequeue on the same lane in one cycle: both take effect and count is unchanged.
  - Enqueues on both lanes in one cycle are both accepted if both RDY.
- Latency: an enqueued item is visible on out_first no earlier than the cycle after its enqueue edge. There is no combinational enq-to-first path.
- Full/empty:
  - A full lane deasserts its RDY until a dequeue from that lane completes; RDY returns the next cycle.
  - Empty current lane gives out_deq__RDY=0, even when the other lane holds data.
- Pointers wrap modulo DEPTH. count alone distinguishes full from empty.

Optional Feature:
- Macro: FIFO_PONG_MERGE_PIPE_EN.
- Defined:
  - inN_enq__RDY = (countN != DEPTH) | (out_deq__ENA & out_deq__RDY & turn==N).
  - A full lane accepts a new item in the same cycle its head is dequeued; count stays DEPTH.
  - This creates a combinational out_deq__ENA to inN_enq__RDY path. Upstream must not loop it back combinationally.
- Undefined: RDY depends on count only. A full lane needs one bubble cycle after a dequeue.

Test Plan:
- Reset, then idle 3 cycles -> in0_enq__RDY=1, in1_enq__RDY=1, out_deq__RDY=0, out_first=0, out_lane=0.
- Enq lane0 A0,A1 and lane1 B0,B1 (one per lane per cycle), then out_deq__ENA held 4 cycles -> out_first sequence A0,B0,A1,B1; out_lane 0,1,0,1; both counts end at 0.
- Enq lane1 0x11 only, hold out_deq__ENA 5 cycles -> out_deq__RDY stays 0, no dequeue. Then enq lane0 0x22 -> next cycle out_first=0x22; deq; following cycle out_first=0x11.
- DEPTH=2: enq lane0 three times back-to-back, no deq -> third ENA ignored with in0_enq__RDY=0 and count0=2. Dequeue 0x01 -> in0_enq__RDY=1 next cycle (macro off) or same cycle (macro on); sequence continues from 0x02 with no loss.
- Same-cycle enq+deq on lane0 with count0=1 -> count0 stays 1; out_first shows the new item after lane1's turn completes.
- Fill both lanes, assert nRST=0 for 1 cycle mid-stream, then enq lane0 0x5A -> prior data gone; next cycle out_first=0x5A, out_lane=0.
